jls_stream_parser: RTL
======================

Name: jls_stream_parser

Overview:
- Front end of the JPEG-LS decoder path. It is the receiving end of the byte stream that jls_encoder emits (ovalid/odata).
- Parses SOI, SOF55, SOS and EOI markers, skips any other length-prefixed segment, and extracts image width and height.
- Removes JPEG-LS marker bit-stuffing from the scan data and hands MSB-aligned bit chunks to the downstream context/Golomb decoder.
- Byte-in, chunk-out; no backpressure, same as the encoder side.

Parameters:
- MAXLEN_LEVEL, 12, width field size; legal width range is 1 .. (1<<MAXLEN_LEVEL)-1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- ivalid  input  1  idata valid this cycle.
- idata  input  8  stream byte.
- width  output  MAXLEN_LEVEL  image width (X from SOF55); valid while hvalid_lvl=1.
- height  output  16  image height (Y from SOF55).
- hvalid  output  1  one-cycle pulse when the SOS header completes; scan data follows.
- ovalid  output  1  chunk valid.
- obits  output  16  payload bits, MSB-aligned; unused LSBs are 0.
- ocnt  output  5  number of valid bits in obits: 8 or 15.
- done  output  1  one-cycle pulse on EOI.
- error  output  1  sticky protocol error.

Behaviour:
- Reset: every output is 0; state goes to S_SOI0; any held byte is discarded.
- Reset mid-operation has the same effect.
- All outputs are registered: one-cycle latency from the deciding input byte.
- The FSM advances only on ivalid=1. Idle cycles change nothing.
- State S_SOI0: wait for FF. S_SOI1: D8 -> S_MK0; any other byte -> S_SOI0.
- S_MK0: expect FF, otherwise error.
- S_MK1: the marker code.
  - FF: fill byte, stay in S_MK1.
  - F7 (SOF55): go to S_LEN.
  - DA (SOS): go to S_LEN.
  - D9 (EOI) before any SOS: error.
  - D8: error.
  - Any other code: go to S_LEN, then S_SKIP.
- S_LEN: 2-byte big-endian length L, counted in a 16-bit counter. L<2 -> error. Segment body = L-2 bytes.
- S_SOF: body of 9 bytes: P, Y(16), X(16), Nf, C, H/V, Tq.
  - Error if P!=8, Nf!=1, Y==0, X==0, or X>(1<<MAXLEN_LEVEL)-1.
  - Remaining fields are ignored.
  - width and height are latched here.
- S_SOS: body of 6 bytes: Ns, C, Tm, NEAR, ILV, Al/Ah.
  - Error if Ns!=1, NEAR!=0, or if no SOF55 has been seen yet.
  - After the last body byte: hvalid=1 for one cycle, then go to S_SCAN.
- S_SKIP: consume L-2 bytes, then go to S_MK0. L=2 returns to S_MK0 directly.
- S_SCAN:
  - Byte b!=FF: ovalid=1, obits={b,8'h00}, ocnt=8.
  - b==FF: hold it, no output, go to S_SCAN_FF.
- S_SCAN_FF, next byte b:
  - b[7]==0: ovalid=1, obits={8'hFF,b[6:0],1'b0}, ocnt=15; go to S_SCAN.
  - b==FF: the held FF was a fill byte; stay in S_SCAN_FF, no output.
  - b==D9: done=1, go to S_SOI0. The held FF is never emitted.
  - Any other b with b[7]==1: error.
- Error: error=1 and state S_ERR. Latches until rst. In S_ERR, ovalid, hvalid and done stay 0.
- width and height hold their values until the next SOF55 or reset.
- Back-to-back images are supported: after done, a new SOI is accepted with no reset.

Decomposition:
- jls_pkg holds:
  - marker constants: M_SOI=8'hD8, M_EOI=8'hD9, M_SOF55=8'hF7, M_SOS=8'hDA.
  - SOF55_BODY=9 and SOS_BODY=6.
  - the state enum: S_SOI0, S_SOI1, S_MK0, S_MK1, S_LEN, S_SOF, S_SOS, S_SKIP, S_SCAN, S_SCAN_FF, S_ERR.
- One sub-module, jls_unstuffer: owns S_SCAN/S_SCAN_FF, the held-FF register and output packing. Its inputs are byte+valid+scan_en; its outputs are ovalid/obits/ocnt/eoi/mk_err.

Test Plan:
- Header parse: send FF D8 FF F7 00 0B 08 00 02 00 04 01 01 11 00 FF DA 00 08 01 01 00 00 00 00 -> width=4, height=2, hvalid pulse exactly 1 cycle after the last byte, error=0.
- Scan and EOI: after the header send 12 FF 3C FF D9 -> first chunk obits=0x1200 ocnt=8; on 3C chunk obits=0xFF78 ocnt=15; done pulse on D9; no chunk for the final FF.
- Segment skip and fill: insert FF E0 00 04 AA BB and one extra FF fill byte before F7 -> the header is parsed identically; no ovalid during the skip.
- Header errors: P=0x0C -> error=1 after that byte and stays 1 through later traffic. Separately, X=0x1000 with MAXLEN_LEVEL=12 -> error=1.
- Bad in-scan marker: in scan send FF D0 -> error=1, no chunk emitted, done never pulses.
- Reset mid-scan: assert rst for 1 cycle while an FF is held, then send a full new stream -> no stale chunk, all outputs 0 during reset, second image parses and reaches done. Gaps with ivalid=0 between bytes give identical results.

Source files
------------

// File: rtl/jls_pkg.sv
// Shared constants and state encoding for the JPEG-LS stream parser.
package jls_pkg;

  localparam logic [7:0] M_SOI   = 8'hD8;
  localparam logic [7:0] M_EOI   = 8'hD9;
  localparam logic [7:0] M_SOF55 = 8'hF7;
  localparam logic [7:0] M_SOS   = 8'hDA;

  localparam int SOF55_BODY = 9;
  localparam int SOS_BODY   = 6;

  typedef enum logic [3:0] {
    S_SOI0, S_SOI1, S_MK0, S_MK1, S_LEN, S_SOF, S_SOS,
    S_SKIP, S_SCAN, S_SCAN_FF, S_ERR
  } state_e;

endpackage

// File: rtl/jls_unstuffer.sv
// Scan-data unstuffer: strips the stuffed zero bit after FF and packs MSB-aligned chunks.
module jls_unstuffer
  import jls_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ivalid,
  input  logic [7:0]  idata,
  input  logic        scan_en,
  output logic        ovalid,
  output logic [15:0] obits,
  output logic [4:0]  ocnt,
  output logic        eoi,
  output logic        mk_err
);

  state_e      st_q;
  logic        ovalid_q;
  logic [15:0] obits_q;
  logic [4:0]  ocnt_q;
  logic        held;

  assign held   = (st_q == S_SCAN_FF);
  // Marker decisions are combinational strobes so the parser reacts on the same byte.
  assign eoi    = scan_en && ivalid && held && (idata == M_EOI);
  assign mk_err = scan_en && ivalid && held && idata[7] &&
                  (idata != 8'hFF) && (idata != M_EOI);

  assign ovalid = ovalid_q;
  assign obits  = obits_q;
  assign ocnt   = ocnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_SCAN;
      ovalid_q <= 1'b0;
      obits_q  <= '0;
      ocnt_q   <= '0;
    end else begin
      ovalid_q <= 1'b0;
      obits_q  <= '0;
      ocnt_q   <= '0;
      if (!scan_en) begin
        st_q <= S_SCAN;
      end else if (ivalid) begin
        if (!held) begin
          if (idata == 8'hFF) begin
            st_q <= S_SCAN_FF;
          end else begin
            ovalid_q <= 1'b1;
            obits_q  <= {idata, 8'h00};
            ocnt_q   <= 5'd8;
          end
        end else if (!idata[7]) begin
          ovalid_q <= 1'b1;
          obits_q  <= {8'hFF, idata[6:0], 1'b0};
          ocnt_q   <= 5'd15;
          st_q     <= S_SCAN;
        end else if (idata != 8'hFF) begin
          st_q <= S_SCAN;
        end
      end
    end
  end

endmodule

// File: rtl/jls_stream_parser.sv
// JPEG-LS front end: marker/header parser with width/height extraction feeding the unstuffer.
module jls_stream_parser
  import jls_pkg::*;
#(
  parameter int MAXLEN_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ivalid,
  input  logic [7:0]              idata,
  output logic [MAXLEN_LEVEL-1:0] width,
  output logic [15:0]             height,
  output logic                    hvalid,
  output logic                    ovalid,
  output logic [15:0]             obits,
  output logic [4:0]              ocnt,
  output logic                    done,
  output logic                    error
);

  localparam logic [15:0] XMAX = 16'((1 << MAXLEN_LEVEL) - 1);

  state_e                  state_q;
  logic [7:0]              mk_q, hi_q;
  logic [15:0]             cnt_q, y_q;
  logic [MAXLEN_LEVEL-1:0] x_q, width_q;
  logic [15:0]             height_q;
  logic                    sof_seen_q, hvalid_q, done_q, error_q;
  logic [15:0]             pair16;
  logic                    us_eoi, us_err;

  assign pair16 = {hi_q, idata};

  assign width  = width_q;
  assign height = height_q;
  assign hvalid = hvalid_q;
  assign done   = done_q;
  assign error  = error_q;

  jls_unstuffer u_unstuff (
    .clk    (clk),
    .rst    (rst),
    .ivalid (ivalid),
    .idata  (idata),
    .scan_en(state_q == S_SCAN),
    .ovalid (ovalid),
    .obits  (obits),
    .ocnt   (ocnt),
    .eoi    (us_eoi),
    .mk_err (us_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SOI0;
      mk_q       <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      y_q        <= '0;
      x_q        <= '0;
      width_q    <= '0;
      height_q   <= '0;
      sof_seen_q <= 1'b0;
      hvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      hvalid_q <= 1'b0;
      done_q   <= 1'b0;
      if (ivalid) begin
        unique case (state_q)
          S_SOI0: if (idata == 8'hFF) state_q <= S_SOI1;
          S_SOI1: state_q <= (idata == M_SOI) ? S_MK0 : S_SOI0;
          S_MK0: begin
            if (idata == 8'hFF) state_q <= S_MK1;
            else begin error_q <= 1'b1; state_q <= S_ERR; end
          end
          S_MK1: begin
            mk_q  <= idata;
            cnt_q <= '0;
            if (idata == M_EOI || idata == M_SOI) begin
              error_q <= 1'b1; state_q <= S_ERR;
            end else if (idata != 8'hFF) begin
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (cnt_q == 16'd0) begin
              hi_q  <= idata;
              cnt_q <= 16'd1;
            end else if (pair16 < 16'd2) begin
              error_q <= 1'b1; state_q <= S_ERR;
            end else begin
              cnt_q <= '0;
              // SOF55/SOS bodies have fixed layouts; only unknown segments honour L.
              if (mk_q == M_SOF55)     state_q <= S_SOF;
              else if (mk_q == M_SOS)  state_q <= S_SOS;
              else if (pair16 == 16'd2) state_q <= S_MK0;
              else begin
                cnt_q   <= pair16 - 16'd2;
                state_q <= S_SKIP;
              end
            end
          end
          S_SOF: begin
            cnt_q <= cnt_q + 16'd1;
            case (cnt_q[3:0])
              4'd0: if (idata != 8'd8) begin error_q <= 1'b1; state_q <= S_ERR; end
              4'd1, 4'd3: hi_q <= idata;
              4'd2: begin
                if (pair16 == 16'd0) begin error_q <= 1'b1; state_q <= S_ERR; end
                else y_q <= pair16;
              end
              4'd4: begin
                if (pair16 == 16'd0 || pair16 > XMAX) begin error_q <= 1'b1; state_q <= S_ERR; end
                else x_q <= pair16[MAXLEN_LEVEL-1:0];
              end
              4'd5: if (idata != 8'd1) begin error_q <= 1'b1; state_q <= S_ERR; end
              default: ;
            endcase
            if (cnt_q == 16'(SOF55_BODY - 1)) begin
              width_q    <= x_q;
              height_q   <= y_q;
              sof_seen_q <= 1'b1;
              state_q    <= S_MK0;
            end
          end
          S_SOS: begin
            cnt_q <= cnt_q + 16'd1;
            case (cnt_q[3:0])
              4'd0: if (idata != 8'd1 || !sof_seen_q) begin error_q <= 1'b1; state_q <= S_ERR; end
              4'd3: if (idata != 8'd0) begin error_q <= 1'b1; state_q <= S_ERR; end
              default: ;
            endcase
            if (cnt_q == 16'(SOS_BODY - 1)) begin
              hvalid_q <= 1'b1;
              state_q  <= S_SCAN;
            end
          end
          S_SKIP: begin
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_q <= S_MK0;
          end
          S_SCAN: begin
            if (us_eoi) begin
              done_q  <= 1'b1;
              state_q <= S_SOI0;
            end else if (us_err) begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
